// File: rtl/load_store_unit_if.sv
// load_store_unit_if -- request/response and data-memory bus of the load/store unit.
//   Request side : req_valid, req_ready, req_is_store, req_addr, req_wdata
//   Response side: resp_valid, resp_rdata, resp_err
//   Memory side  : mem_read_enable, mem_write_enable, address, write_data, mem_data
// slave  : the load/store unit itself.
// master : the environment (pipeline MEM stage plus data memory).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] mem_data;

  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, mem_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_enable, mem_write_enable, address, write_data
  );

  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, mem_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_enable, mem_write_enable, address, write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding load/store unit for a pipeline MEM stage.
// Accepts one word access at a time, checks alignment and range, drives one
// strobe cycle to a registered data memory and returns a one-cycle response.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : load_store_unit_if.slave (request, response and memory signals)
// Parameter:
//   MEM_BYTES : byte size of the attached data memory
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 32
) (
  input logic              clk,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_CAP,
    WR,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        store_q, store_d;
  logic        err_q, err_d;
  logic        accept;
  logic        req_err;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= MEM_BYTES);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)               state_d = RESP;
          else if (bus.req_is_store) state_d = WR;
          else                       state_d = RD;
        end
      end
      RD:      state_d = RD_CAP;
      RD_CAP:  state_d = RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs; the latched store flag also gates the strobes so a read
  // and a write can never coincide.
  always_comb begin
    bus.req_ready        = (state_q == IDLE);
    bus.resp_valid       = (state_q == RESP);
    bus.mem_read_enable  = (state_q == RD) && !store_q;
    bus.mem_write_enable = (state_q == WR) &&  store_q;
  end

  // Request latch and response data
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    store_d = store_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      store_d = bus.req_is_store;
      err_d   = req_err;
      rdata_d = '0;
    end else if (state_q == RD_CAP) begin
      // Memory zeroes its output once the read strobe is gone, so capture now.
      rdata_d = bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.address    = addr_q;
  assign bus.write_data = wdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Registered data memory: read data valid the cycle after the read strobe, 0 otherwise.
  logic [31:0] tb_mem [8];
  logic [31:0] mem_rd = '0;
  always @(posedge clk) begin
    if (bus.mem_write_enable) tb_mem[bus.address[4:2]] <= bus.write_data;
    if (bus.mem_read_enable) mem_rd <= tb_mem[bus.address[4:2]];
    else                     mem_rd <= '0;
  end
  assign bus.mem_data = mem_rd;

  // Reference memory contents, updated from the request stream.
  logic [31:0] ref_mem [8];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Issues one request from #1 after a rising edge and observes it until resp_valid.
  task automatic run_txn(input logic st, input logic [31:0] a, input logic [31:0] wd,
                         input bit hold, output int lat, output logic [31:0] rd,
                         output logic er, output int n_re, output int n_we,
                         output bit bus_ok, output int acc_cyc);
    int  w;
    bit  seen;
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) bus.req_valid = 1'b0;
    lat = 0; n_re = 0; n_we = 0; bus_ok = 1'b1; seen = 1'b0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (bus.mem_read_enable === 1'b1)  n_re++;
      if (bus.mem_write_enable === 1'b1) n_we++;
      if (bus.address !== a || bus.write_data !== wd || bus.req_ready !== 1'b0) bus_ok = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        seen = 1'b1; lat = n; rd = bus.resp_rdata; er = bus.resp_err;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.mem_read_enable,
         bus.mem_write_enable, bus.address, bus.write_data} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rv=%b rdata=%h err=%b re=%b we=%b addr=%h wdata=%h, required ready=1 and all others 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.mem_read_enable,
               bus.mem_write_enable, bus.address, bus.write_data);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.address !== 32'h0) begin
      failures++;
      $display("FAIL reset_release_idle: ready=%b rv=%b addr=%h, required 1 0 00000000",
               bus.req_ready, bus.resp_valid, bus.address);
    end
  endtask

  task automatic test_load();
    int lat, nr, nw, ac; logic [31:0] rd; logic er; bit ok;
    run_txn(1'b0, 32'h14, 32'h0, 1'b0, lat, rd, er, nr, nw, ok, ac);
    checks++;
    if (lat !== 3 || rd !== 32'h5 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_0x14: lat=%0d rdata=%h err=%b, required lat=3 rdata=00000005 err=0", lat, rd, er);
    end
    checks++;
    if (nr !== 1 || nw !== 0 || !ok) begin
      failures++;
      $display("FAIL load_0x14_strobes: re_cycles=%0d we_cycles=%0d bus_ok=%b, required 1 0 1", nr, nw, ok);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'h5) begin
      failures++;
      $display("FAIL load_after_resp: rv=%b ready=%b rdata=%h, required 0 1 00000005",
               bus.resp_valid, bus.req_ready, bus.resp_rdata);
    end
  endtask

  task automatic test_store();
    int lat, nr, nw, ac; logic [31:0] rd; logic er; bit ok;
    run_txn(1'b1, 32'h0C, 32'hDEADBEEF, 1'b0, lat, rd, er, nr, nw, ok, ac);
    ref_mem[3] = 32'hDEADBEEF;
    checks++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b0 || nw !== 1 || nr !== 0 || !ok) begin
      failures++;
      $display("FAIL store_0x0C: lat=%0d rdata=%h err=%b we=%0d re=%0d ok=%b, required 2 00000000 0 1 0 1",
               lat, rd, er, nw, nr, ok);
    end
    run_txn(1'b0, 32'h0C, 32'h0, 1'b0, lat, rd, er, nr, nw, ok, ac);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL load_back_0x0C: lat=%0d rdata=%h err=%b, required 3 deadbeef 0", lat, rd, er);
    end
  endtask

  task automatic test_error();
    int lat, nr, nw, ac; logic [31:0] rd; logic er; bit ok;
    run_txn(1'b0, 32'h06, 32'h0, 1'b0, lat, rd, er, nr, nw, ok, ac);
    checks++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b1 || nr !== 0 || nw !== 0) begin
      failures++;
      $display("FAIL misaligned_load: lat=%0d rdata=%h err=%b re=%0d we=%0d, required 1 00000000 1 0 0",
               lat, rd, er, nr, nw);
    end
    run_txn(1'b1, 32'h20, 32'h12345678, 1'b0, lat, rd, er, nr, nw, ok, ac);
    checks++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b1 || nr !== 0 || nw !== 0) begin
      failures++;
      $display("FAIL out_of_range_store: lat=%0d rdata=%h err=%b re=%0d we=%0d, required 1 00000000 1 0 0",
               lat, rd, er, nr, nw);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_err !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_held: err=%b rv=%b, required err=1 rv=0", bus.resp_err, bus.resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, nr1, nw1, nr2, nw2, ac1, ac2; logic [31:0] rd1, rd2; logic er1, er2; bit ok1, ok2;
    run_txn(1'b0, 32'h00, 32'h0, 1'b1, lat1, rd1, er1, nr1, nw1, ok1, ac1);
    run_txn(1'b0, 32'h04, 32'h0, 1'b1, lat2, rd2, er2, nr2, nw2, ok2, ac2);
    bus.req_valid = 1'b0;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h1 || lat1 !== 3 || lat2 !== 3) begin
      failures++;
      $display("FAIL b2b_results: rdata=%h,%h lat=%0d,%0d, required 00000000,00000001 lat 3,3", rd1, rd2, lat1, lat2);
    end
    checks++;
    if (ac2 - ac1 !== 4 || !ok1 || !ok2) begin
      failures++;
      $display("FAIL b2b_spacing: accept_gap=%0d ready_low_ok=%b,%b, required gap 4 and ok 1,1", ac2 - ac1, ok1, ok2);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nr, nw, ac, w; logic [31:0] rd; logic er; bit ok, rv_seen;
    bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.mem_read_enable,
         bus.mem_write_enable, bus.address, bus.write_data} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid_outputs: ready=%b rv=%b rdata=%h err=%b re=%b we=%b addr=%h, required ready=1 and all others 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.mem_read_enable,
               bus.mem_write_enable, bus.address);
    end
    rv_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0) rv_seen = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0) rv_seen = 1'b1;
    end
    checks++;
    if (rv_seen || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_dropped: resp_valid_seen=%b ready=%b, required 0 1", rv_seen, bus.req_ready);
    end
    run_txn(1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er, nr, nw, ok, ac);
    checks++;
    if (lat !== 3 || rd !== ref_mem[4] || er !== 1'b0 || nr !== 1) begin
      failures++;
      $display("FAIL reset_mid_next_load: lat=%0d rdata=%h err=%b re=%0d, required 3 %h 0 1", lat, rd, er, nr, ref_mem[4]);
    end
  endtask

  task automatic test_random();
    int lat, nr, nw, ac, kind, exp_lat;
    logic [31:0] rd, a, wd, exp_rd;
    logic er, st, exp_err;
    bit ok;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)       a = 32'($urandom_range(0, 7)) * 4;
      else if (kind == 7) a = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(1, 3));
      else if (kind == 8) a = 32 + 32'($urandom_range(0, 7)) * 4;
      else                a = ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
      st = 1'($urandom_range(0, 1));
      wd = $urandom();
      exp_err = (a % 4 != 0) || (a >= 32);
      exp_lat = exp_err ? 1 : (st ? 2 : 3);
      exp_rd  = (exp_err || st) ? 32'h0 : ref_mem[a / 4];
      run_txn(st, a, wd, 1'b0, lat, rd, er, nr, nw, ok, ac);
      if (!exp_err && st) ref_mem[a / 4] = wd;
      checks++;
      if (lat !== exp_lat || rd !== exp_rd || er !== exp_err) begin
        failures++;
        $display("FAIL random_txn%0d st=%b addr=%h: lat=%0d rdata=%h err=%b, required %0d %h %b",
                 t, st, a, lat, rd, er, exp_lat, exp_rd, exp_err);
      end
      checks++;
      if (nr !== ((!exp_err && !st) ? 1 : 0) || nw !== ((!exp_err && st) ? 1 : 0) || !ok) begin
        failures++;
        $display("FAIL random_strobes%0d st=%b addr=%h: re=%0d we=%0d bus_ok=%b, required re=%0d we=%0d ok=1",
                 t, st, a, nr, nw, ok, (!exp_err && !st) ? 1 : 0, (!exp_err && st) ? 1 : 0);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      tb_mem[k]  = 32'(k);
      ref_mem[k] = 32'(k);
    end
    test_reset();
    test_load();
    test_store();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
